// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI register command sequencer: header bit
// positions, default address width and the sequencer state encoding.
package spi_reg_ctrl_pkg;

  localparam int CMD_RW_BIT     = 7;
  localparam int CMD_BURST_BIT  = 6;
  localparam int DEFAULT_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RD_HOLD
  } state_e;

endpackage

// File: rtl/cdc_pulse_sync.sv
// Multi-flop synchroniser for a slow asynchronous level, with a registered
// level output and a one-clk rising-edge pulse aligned to that level.
module cdc_pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level_out,
  output logic rise_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              level_q;
  logic              level_d;
  logic              rise_q;
  logic              rise_d;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = async_in;
      end else begin : g_rest
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  // level_q and rise_q change on the same edge so consumers see them coherently
  always_comb begin
    level_d = sync_q[STAGES-1];
    rise_d  = sync_q[STAGES-1] & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command sequencer between the SPI byte bridge and the register file:
// decodes a header byte, issues write/read strobes and supplies the reply byte.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_abort
);

  logic byte_valid;
  logic byte_level_unused;
  logic cs_s;
  logic cs_rise;

  cdc_pulse_sync #(.STAGES(SYNC_STAGES)) u_byte_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (byte_sync),
    .level_out (byte_level_unused),
    .rise_out  (byte_valid)
  );

  cdc_pulse_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (cs_n),
    .level_out (cs_s),
    .rise_out  (cs_rise)
  );

  state_e            state_q;
  logic              burst_q;
  logic [7:0]        data_out_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [7:0]        reg_wdata_q;
  logic              reg_we_q;
  logic              reg_re_q;
  logic              frame_abort_q;
  logic              abort_d;

  // A burst parked waiting for its next byte is a normal end of frame
  always_comb begin
    abort_d = 1'b0;
    case (state_q)
      ST_RD_REQ, ST_RD_CAP:    abort_d = 1'b1;
      ST_WR_DATA, ST_RD_HOLD:  abort_d = ~burst_q;
      default:                 abort_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      burst_q       <= 1'b0;
      data_out_q    <= 8'h00;
      reg_addr_q    <= '0;
      reg_wdata_q   <= 8'h00;
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      frame_abort_q <= 1'b0;
      if (cs_rise) begin
        // Deselect overrides any byte arriving in the same cycle
        state_q       <= ST_IDLE;
        data_out_q    <= 8'h00;
        frame_abort_q <= abort_d;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byte_valid && !cs_s) begin
              reg_addr_q <= data_in[ADDR_W-1:0];
              burst_q    <= data_in[CMD_BURST_BIT];
              if (data_in[CMD_RW_BIT]) begin
                state_q <= ST_WR_DATA;
              end else begin
                state_q  <= ST_RD_REQ;
                reg_re_q <= 1'b1;
              end
            end
          end
          ST_WR_DATA: begin
            if (byte_valid) begin
              reg_we_q    <= 1'b1;
              reg_wdata_q <= data_in;
              if (!burst_q) state_q <= ST_IDLE;
            end else if (reg_we_q && burst_q) begin
              // Advance only after the strobe so reg_addr is stable while reg_we is high
              reg_addr_q <= reg_addr_q + ADDR_W'(1);
            end
          end
          ST_RD_REQ: state_q <= ST_RD_CAP;
          ST_RD_CAP: begin
            data_out_q <= reg_rdata;
            state_q    <= ST_RD_HOLD;
          end
          ST_RD_HOLD: begin
            if (byte_valid) begin
              if (burst_q) begin
                reg_addr_q <= reg_addr_q + ADDR_W'(1);
                reg_re_q   <= 1'b1;
                state_q    <= ST_RD_REQ;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_out_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign frame_abort = frame_abort_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: bridge-like byte driver, register-file responder,
// directed vector table, hand-written corner sequences and random frames.
module tb_spi_reg_ctrl;

  localparam int SCLK_HALF = 80;    // sclk period = 16 clk periods
  localparam int BYTE_TIME = 1280;  // 8 sclk periods per byte

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       frame_abort;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.SYNC_STAGES(2), .ADDR_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .cs_n        (cs_n),
    .byte_sync   (byte_sync),
    .data_in     (data_in),
    .data_out    (data_out),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy),
    .frame_abort (frame_abort)
  );

  function automatic logic [7:0] preload_val(input int i);
    return (i == 10) ? 8'hA7 : 8'(i ^ 'h5A);
  endfunction

  // Register-file responder: read data valid the cycle after reg_re, noise otherwise
  logic [7:0] resp_mem [64];
  logic       preload_req = 1'b0;
  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 64; i++) resp_mem[i] <= preload_val(i);
    end else if (reg_we) begin
      resp_mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_re ? resp_mem[reg_addr] : 8'($urandom);
  end

  // Strobe monitor, sampled mid-cycle
  int we_addr_q[$];
  int we_data_q[$];
  int re_addr_q[$];
  int abort_cnt = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(int'(reg_addr));
      we_data_q.push_back(int'(reg_wdata));
    end
    if (reg_re) re_addr_q.push_back(int'(reg_addr));
    if (reg_we && reg_re) overlap_cnt++;
    if (frame_abort) abort_cnt++;
  end

  logic [7:0] model_mem [64];
  logic [7:0] dout_seen [5];
  int n_checks = 0;
  int n_pass = 0;
  int we_base, re_base, abort_base, overlap_base;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic mark_frame();
    we_base      = we_addr_q.size();
    re_base      = re_addr_q.size();
    abort_base   = abort_cnt;
    overlap_base = overlap_cnt;
  endtask

  task automatic do_preload();
    for (int i = 0; i < 64; i++) model_mem[i] = preload_val(i);
    preload_req = 1'b1;
    @(posedge clk);
    #1 preload_req = 1'b0;
  endtask

  // One byte as the bridge delivers it; returns data_out at the following sclk fall
  task automatic send_byte(input logic [7:0] b, output logic [7:0] dout);
    @(posedge clk);
    #($urandom_range(1, 9));
    data_in   = b;
    byte_sync = 1'b1;
    #(SCLK_HALF) dout = data_out;
    #(SCLK_HALF) byte_sync = 1'b0;
    #(BYTE_TIME - 2 * SCLK_HALF);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int npay, input int pay [4]);
    logic [7:0] d;
    mark_frame();
    for (int i = 0; i < 5; i++) dout_seen[i] = 8'hEE;
    cs_n = 1'b0;
    repeat (20) @(posedge clk);
    send_byte(cmd, d);
    dout_seen[0] = d;
    for (int i = 0; i < npay; i++) begin
      send_byte(8'(pay[i]), d);
      dout_seen[i+1] = d;
    end
    cs_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic is_wr, input int exp_abort,
                             input int exp_n, input int n_val, input int ea [5], input int ev [5]);
    int idx;
    check({tag, " frame_abort"}, abort_cnt - abort_base, exp_abort);
    check({tag, " we_re_overlap"}, overlap_cnt - overlap_base, 0);
    check({tag, " data_out_idle"}, int'(data_out), 0);
    check({tag, " busy_idle"}, int'(busy), 0);
    check({tag, " n_we"}, we_addr_q.size() - we_base, is_wr ? exp_n : 0);
    check({tag, " n_re"}, re_addr_q.size() - re_base, is_wr ? 0 : exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (is_wr) begin
        idx = we_base + i;
        check($sformatf("%s we_addr[%0d]", tag, i), (idx < we_addr_q.size()) ? we_addr_q[idx] : -1, ea[i]);
        check($sformatf("%s we_data[%0d]", tag, i), (idx < we_data_q.size()) ? we_data_q[idx] : -1, ev[i]);
      end else begin
        idx = re_base + i;
        check($sformatf("%s re_addr[%0d]", tag, i), (idx < re_addr_q.size()) ? re_addr_q[idx] : -1, ea[i]);
      end
    end
    for (int i = 0; i < n_val; i++)
      check($sformatf("%s data_out[%0d]", tag, i), int'(dout_seen[i]), ev[i]);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         npay;
    int         pay [4];
    int         exp_abort;
    int         exp_n;
    int         ea [5];
    int         ev [5];
  } vec_t;

  vec_t vecs [6];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] d;
    int         found;
    int         z5 [5];
    int         ea10 [5];

    vecs[0] = '{8'h85, 1, '{'h3C, 0, 0, 0}, 0, 1, '{5, 0, 0, 0, 0}, '{'h3C, 0, 0, 0, 0}};
    vecs[1] = '{8'h0A, 1, '{0, 0, 0, 0}, 0, 1, '{10, 0, 0, 0, 0}, '{'hA7, 0, 0, 0, 0}};
    vecs[2] = '{8'hFE, 3, '{'h11, 'h22, 'h33, 0}, 0, 3, '{62, 63, 0, 0, 0}, '{'h11, 'h22, 'h33, 0, 0}};
    vecs[3] = '{8'h41, 3, '{0, 0, 0, 0}, 0, 4, '{1, 2, 3, 4, 0}, '{'h5B, 'h58, 'h59, 'h5E, 0}};
    vecs[4] = '{8'h83, 0, '{0, 0, 0, 0}, 1, 0, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
    vecs[5] = '{8'h0A, 0, '{0, 0, 0, 0}, 1, 1, '{10, 0, 0, 0, 0}, '{'hA7, 0, 0, 0, 0}};
    z5   = '{0, 0, 0, 0, 0};
    ea10 = '{10, 0, 0, 0, 0};

    do_preload();
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", int'(data_out), 0);
    check("reset reg_addr", int'(reg_addr), 0);
    check("reset reg_wdata", int'(reg_wdata), 0);
    check("reset reg_we", int'(reg_we), 0);
    check("reset reg_re", int'(reg_re), 0);
    check("reset busy", int'(busy), 0);
    check("reset frame_abort", int'(frame_abort), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    for (int v = 0; v < 6; v++) begin
      int nv;
      run_frame(vecs[v].cmd, vecs[v].npay, vecs[v].pay);
      nv = vecs[v].cmd[7] ? 0 : ((vecs[v].exp_n < vecs[v].npay + 1) ? vecs[v].exp_n : vecs[v].npay + 1);
      check_frame($sformatf("vec%0d", v), vecs[v].cmd[7], vecs[v].exp_abort,
                  vecs[v].exp_n, nv, vecs[v].ea, vecs[v].ev);
    end

    // Bytes while deselected are ignored
    mark_frame();
    cs_n = 1'b1;
    send_byte(8'h85, d);
    send_byte(8'h12, d);
    check_frame("idle_deselected", 1'b1, 0, 0, 0, z5, z5);

    // Deselect in the same cycle as the data byte: abort wins, no write
    mark_frame();
    cs_n = 1'b0;
    repeat (20) @(posedge clk);
    send_byte(8'h85, d);
    @(posedge clk);
    #4 data_in = 8'h77;
    byte_sync = 1'b1;
    cs_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 byte_sync = 1'b0;
    check_frame("same_cycle_abort", 1'b1, 1, 0, 0, z5, z5);

    // Deselect one clk after a read header: aborted while the read is in flight
    mark_frame();
    cs_n = 1'b0;
    repeat (20) @(posedge clk);
    @(posedge clk);
    #4 data_in = 8'h0A;
    byte_sync = 1'b1;
    #10 cs_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 byte_sync = 1'b0;
    check_frame("abort_rd_req", 1'b0, 1, 1, 0, ea10, z5);

    // Reset while the read data is being captured
    cs_n = 1'b0;
    repeat (20) @(posedge clk);
    @(posedge clk);
    #3 data_in = 8'h0A;
    byte_sync = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (reg_re) found = 1;
    end
    check("rst_mid_read reg_re_seen", found, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    byte_sync = 1'b0;
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_read data_out", int'(data_out), 0);
    check("rst_mid_read reg_addr", int'(reg_addr), 0);
    check("rst_mid_read reg_wdata", int'(reg_wdata), 0);
    check("rst_mid_read reg_re", int'(reg_re), 0);
    check("rst_mid_read reg_we", int'(reg_we), 0);
    check("rst_mid_read busy", int'(busy), 0);
    check("rst_mid_read frame_abort", int'(frame_abort), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    run_frame(8'h85, 1, '{1, 0, 0, 0});
    check_frame("after_reset_write", 1'b1, 0, 1, 0, '{5, 0, 0, 0, 0}, '{1, 0, 0, 0, 0});

    // Random frames against a memory-array reference
    do_preload();
    for (int f = 0; f < 40; f++) begin
      logic rw, bu;
      int a, np, n, nv;
      int pay [4];
      int ea [5];
      int ev [5];
      rw = 1'($urandom_range(0, 1));
      bu = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 63);
      np = bu ? $urandom_range(0, 4) : (($urandom_range(0, 5) == 0) ? 0 : 1);
      for (int i = 0; i < 4; i++) pay[i] = $urandom_range(0, 255);
      for (int i = 0; i < 5; i++) begin
        ea[i] = 0;
        ev[i] = 0;
      end
      if (rw) begin
        n  = np;
        nv = 0;
        for (int i = 0; i < n; i++) begin
          ea[i] = (a + i) % 64;
          ev[i] = pay[i];
          model_mem[ea[i]] = 8'(pay[i]);
        end
      end else begin
        n  = bu ? np + 1 : 1;
        nv = n;
        for (int i = 0; i < n; i++) begin
          ea[i] = (a + i) % 64;
          ev[i] = int'(model_mem[ea[i]]);
        end
      end
      run_frame({rw, bu, 6'(a)}, np, pay);
      check_frame($sformatf("rand%0d", f), rw, (!bu && np == 0) ? 1 : 0, n, nv, ea, ev);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
